mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported memory between two requesters: port 0 is instruction fetch and port 1 is data access.
- Sequences each access through a request/ack handshake with the memory.
- Drives the select of the downstream 2-to-1 address/data multiplexers.
- Includes a watchdog that aborts accesses the memory never acknowledges.

Parameters:
- TIMEOUT, 16: maximum cycles BUSY waits for mem_ack_i before aborting; legal range 1..255.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- req0_i  input  1  port 0 (fetch) access request.
- req1_i  input  1  port 1 (data) access request.
- mem_ack_i  input  1  memory completion, one-cycle pulse.
- sel_o  output  1  mux select: 0 routes port 0, 1 routes port 1.
- mem_en_o  output  1  memory enable, held high while an access is outstanding.
- gnt0_o  output  1  port 0 owns the memory.
- gnt1_o  output  1  port 1 owns the memory.
- done0_o  output  1  port 0 access complete, one-cycle pulse.
- done1_o  output  1  port 1 access complete, one-cycle pulse.
- err_o  output  1  watchdog abort, one-cycle pulse.
- busy_o  output  1  FSM is not IDLE.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=IDLE, wait_cnt=0, last_gnt=1.
  - All outputs 0, including sel_o.
  - Reset asserted mid-access abandons the access immediately. No done or err pulse is produced.
- FSM states: IDLE, BUSY0, BUSY1. All outputs are registered.
- IDLE:
  - No request pending: remain in IDLE; sel_o holds its last value.
  - Request pending: arbitrate per Optional Feature. On the next edge, enter BUSYn, set sel_o=n, and assert gntn_o=1 and mem_en_o=1.
  - mem_ack_i seen in IDLE is ignored.
- BUSYn:
  - sel_o, gntn_o and mem_en_o are stable for the whole state.
  - wait_cnt increments every cycle starting from 0.
  - Requests are not sampled. Dropping reqn_i mid-access does not cancel the access.
- Completion: mem_ack_i=1 in BUSYn.
  - Next edge: doneN_o=1 for one cycle, gnt and mem_en_o drop, state=IDLE, wait_cnt=0, last_gnt=n.
- Watchdog: wait_cnt==TIMEOUT-1 with no ack.
  - Next edge: err_o=1 for one cycle, no done pulse, state=IDLE, wait_cnt=0, last_gnt=n.
- Simultaneous ack and timeout in the same cycle: ack wins. done pulses; err does not.
- Timing:
  - Minimum access: request in cycle 0, grant visible in cycle 1, ack in cycle 1, done in cycle 2.
  - At least one IDLE cycle separates consecutive grants. There are no back-to-back grants.
- Requester contract:
  - Hold reqn_i until donen_o or err_o.
  - A request still high after done is treated as a new access.
- Invariants:
  - gnt0_o and gnt1_o are never both 1.
  - mem_en_o == gnt0_o | gnt1_o.
  - busy_o == mem_en_o.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are high in IDLE, grant the port not equal to last_gnt. A single request is granted directly. After reset the first contested grant goes to port 0.
- Undefined: fixed priority. Port 1 (data) always wins when both requests are high. last_gnt is still maintained but does not affect arbitration.

Test Plan:
- Single fetch access:
  - Stimulus: reset, then req0_i=1; mem_ack_i pulses 3 cycles after gnt0_o rises.
  - Required: sel_o=0; gnt0_o and mem_en_o high for exactly 3 cycles; one done0_o pulse; busy_o returns to 0.
- Contention, both build variants:
  - Stimulus: req0_i=req1_i=1 held, memory acks each access after 1 cycle, 4 accesses.
  - Without MEM_ARB_RR_EN, required grant order: 1,1,1,1.
  - With MEM_ARB_RR_EN, required grant order: 0,1,0,1.
  - In both builds gnt0_o and gnt1_o are never simultaneously high.
- Watchdog:
  - Stimulus: TIMEOUT=4, req1_i=1, no ack.
  - Required: gnt1_o high for exactly 4 cycles, then one err_o pulse, no done1_o, FSM back in IDLE.
- Ack/timeout collision and stray ack:
  - Ack arriving in the 4th BUSY cycle with TIMEOUT=4 yields done1_o and no err_o.
  - mem_ack_i pulsed while IDLE causes no output change.
- Reset mid-access:
  - Stimulus: rst_i driven low while in BUSY0 with wait_cnt=2.
  - Required: all outputs go 0 immediately without waiting for a clock edge.
  - After rst_i releases, a pending req0_i is granted again from wait_cnt=0.
- Request drop:
  - Stimulus: req0_i deasserted 1 cycle after grant.
  - Required: access continues; done0_o still pulses on ack.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the two requesters, the memory and mem_port_arbiter.
// The arbiter takes the slave view; the environment driving requests/acks takes the master view.
interface mem_port_arbiter_if;
    logic req0_i;
    logic req1_i;
    logic mem_ack_i;
    logic sel_o;
    logic mem_en_o;
    logic gnt0_o;
    logic gnt1_o;
    logic done0_o;
    logic done1_o;
    logic err_o;
    logic busy_o;

    modport slave (
        input  req0_i, req1_i, mem_ack_i,
        output sel_o, mem_en_o, gnt0_o, gnt1_o, done0_o, done1_o, err_o, busy_o
    );

    modport master (
        output req0_i, req1_i, mem_ack_i,
        input  sel_o, mem_en_o, gnt0_o, gnt1_o, done0_o, done1_o, err_o, busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter for a single-ported memory with an ack watchdog.
// Define MEM_ARB_RR_EN for round-robin arbitration; default build uses fixed data-port priority.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
    logic             last_gnt, last_gnt_nx;
    logic             sel_q, sel_nx;
    logic             gnt0_q, gnt0_nx;
    logic             gnt1_q, gnt1_nx;
    logic             mem_en_q, mem_en_nx;
    logic             done0_q, done0_nx;
    logic             done1_q, done1_nx;
    logic             err_q, err_nx;
    logic             pick;
    logic             timeout_hit;

    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

    // pick=1 selects port 1
`ifdef MEM_ARB_RR_EN
    always_comb begin
        pick = 1'b0;
        if (bus.req0_i && bus.req1_i)
            pick = ~last_gnt;
        else
            pick = bus.req1_i;
    end
`else
    always_comb begin
        pick = bus.req1_i;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            wait_cnt <= '0;
            last_gnt <= 1'b1;
            sel_q    <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            mem_en_q <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            last_gnt <= last_gnt_nx;
            sel_q    <= sel_nx;
            gnt0_q   <= gnt0_nx;
            gnt1_q   <= gnt1_nx;
            mem_en_q <= mem_en_nx;
            done0_q  <= done0_nx;
            done1_q  <= done1_nx;
            err_q    <= err_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        last_gnt_nx = last_gnt;
        sel_nx      = sel_q;
        gnt0_nx     = gnt0_q;
        gnt1_nx     = gnt1_q;
        done0_nx    = 1'b0;
        done1_nx    = 1'b0;
        err_nx      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req0_i || bus.req1_i) begin
                    state_nx    = pick ? BUSY1 : BUSY0;
                    sel_nx      = pick;
                    gnt0_nx     = ~pick;
                    gnt1_nx     = pick;
                    wait_cnt_nx = '0;
                end
            end
            BUSY0, BUSY1: begin
                // ack is checked first so it wins over a coincident timeout
                if (bus.mem_ack_i || timeout_hit) begin
                    done0_nx    = bus.mem_ack_i && (state == BUSY0);
                    done1_nx    = bus.mem_ack_i && (state == BUSY1);
                    err_nx      = ~bus.mem_ack_i;
                    state_nx    = IDLE;
                    gnt0_nx     = 1'b0;
                    gnt1_nx     = 1'b0;
                    wait_cnt_nx = '0;
                    last_gnt_nx = (state == BUSY1);
                end else begin
                    wait_cnt_nx = wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx    = IDLE;
                gnt0_nx     = 1'b0;
                gnt1_nx     = 1'b0;
                wait_cnt_nx = '0;
            end
        endcase

        mem_en_nx = gnt0_nx | gnt1_nx;
    end

    assign bus.sel_o    = sel_q;
    assign bus.gnt0_o   = gnt0_q;
    assign bus.gnt1_o   = gnt1_q;
    assign bus.mem_en_o = mem_en_q;
    assign bus.busy_o   = mem_en_q;
    assign bus.done0_o  = done0_q;
    assign bus.done1_o  = done1_q;
    assign bus.err_o    = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter, built with TIMEOUT=4.
// Expected grant order follows MEM_ARB_RR_EN in the same way as the design build.
module tb_mem_port_arbiter;

    logic clk_i;
    logic rst_i;
    int   checks;
    int   failures;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] outs();
        return {bus.sel_o, bus.mem_en_o, bus.gnt0_o, bus.gnt1_o,
                bus.done0_o, bus.done1_o, bus.err_o, bus.busy_o};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        bus.req0_i    = 1'b0;
        bus.req1_i    = 1'b0;
        bus.mem_ack_i = 1'b0;
        rst_i         = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_reset();
        bus.req0_i    = 1'b0;
        bus.req1_i    = 1'b0;
        bus.mem_ack_i = 1'b0;
        rst_i         = 1'b0;
        step();
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", outs(), 8'h00);
        end
        rst_i = 1'b1;
        step();
        step();
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL idle_after_reset: got %b expected %b", outs(), 8'h00);
        end
    endtask

    task automatic test_single_fetch();
        int gnt_cyc = 0;
        int done_cnt = 0;
        int bad_inv = 0;
        int err_cnt = 0;
        bus.req0_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (c == 0) begin
                checks++;
                if ({bus.gnt0_o, bus.sel_o, bus.mem_en_o, bus.busy_o} !== 4'b1011) begin
                    failures++;
                    $display("FAIL fetch_grant: got gnt0/sel/en/busy=%b expected 1011",
                             {bus.gnt0_o, bus.sel_o, bus.mem_en_o, bus.busy_o});
                end
            end
            if (bus.gnt0_o) gnt_cyc++;
            if (bus.done0_o) begin
                done_cnt++;
                bus.req0_i = 1'b0;
            end
            if (bus.err_o) err_cnt++;
            if (bus.mem_en_o !== bus.gnt0_o || bus.gnt1_o !== 1'b0 || bus.sel_o !== 1'b0) bad_inv++;
            bus.mem_ack_i = (bus.gnt0_o && gnt_cyc == 3);
        end
        checks++;
        if (gnt_cyc != 3) begin
            failures++;
            $display("FAIL fetch_gnt_cycles: got %0d expected 3", gnt_cyc);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL fetch_done_pulses: got %0d expected 1", done_cnt);
        end
        checks++;
        if (bad_inv != 0 || err_cnt != 0) begin
            failures++;
            $display("FAIL fetch_en_sel: got bad=%0d err=%0d expected 0 0", bad_inv, err_cnt);
        end
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL fetch_idle_after: got %b expected %b", outs(), 8'h00);
        end
    endtask

    task automatic test_contention();
        logic exp_order [4];
        logic got_order [4];
        int   n_gnt = 0;
        int   n_done = 0;
        int   both = 0;
        int   in_gnt = 0;
`ifdef MEM_ARB_RR_EN
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        got_order = '{1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        bus.req0_i = 1'b1;
        bus.req1_i = 1'b1;
        for (int c = 0; c < 60 && n_done < 4; c++) begin
            step();
            if (bus.gnt0_o && bus.gnt1_o) both++;
            if (bus.gnt0_o || bus.gnt1_o) begin
                in_gnt++;
                if (in_gnt == 1 && n_gnt < 4) begin
                    got_order[n_gnt] = bus.gnt1_o;
                    n_gnt++;
                end
            end else begin
                in_gnt = 0;
            end
            if (bus.done0_o || bus.done1_o) begin
                n_done++;
                if (n_done == 4) begin
                    bus.req0_i = 1'b0;
                    bus.req1_i = 1'b0;
                end
            end
            bus.mem_ack_i = (in_gnt == 2);
        end
        bus.mem_ack_i = 1'b0;
        checks++;
        if (n_done != 4) begin
            failures++;
            $display("FAIL contention_done_count: got %0d expected 4", n_done);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_order[i] !== exp_order[i]) begin
                failures++;
                $display("FAIL contention_order[%0d]: got port %b expected port %b",
                         i, got_order[i], exp_order[i]);
            end
        end
        checks++;
        if (both != 0) begin
            failures++;
            $display("FAIL contention_both_gnt: got %0d cycles expected 0", both);
        end
    endtask

    task automatic test_watchdog();
        int gnt_cyc = 0;
        int err_cnt = 0;
        int done_cnt = 0;
        bus.req1_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.gnt1_o) gnt_cyc++;
            if (bus.done1_o) done_cnt++;
            if (bus.err_o) begin
                err_cnt++;
                bus.req1_i = 1'b0;
            end
        end
        checks++;
        if (gnt_cyc != 4) begin
            failures++;
            $display("FAIL watchdog_gnt_cycles: got %0d expected 4", gnt_cyc);
        end
        checks++;
        if (err_cnt != 1 || done_cnt != 0) begin
            failures++;
            $display("FAIL watchdog_pulses: got err=%0d done=%0d expected err=1 done=0",
                     err_cnt, done_cnt);
        end
        checks++;
        if (outs() !== 8'h80) begin
            failures++;
            $display("FAIL watchdog_idle: got %b expected %b", outs(), 8'h80);
        end
    endtask

    task automatic test_collision();
        int gnt_cyc = 0;
        int err_cnt = 0;
        int done_cnt = 0;
        bus.req1_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.gnt1_o) gnt_cyc++;
            if (bus.err_o) err_cnt++;
            if (bus.done1_o) begin
                done_cnt++;
                bus.req1_i = 1'b0;
            end
            bus.mem_ack_i = (bus.gnt1_o && gnt_cyc == 4);
        end
        bus.mem_ack_i = 1'b0;
        checks++;
        if (done_cnt != 1 || err_cnt != 0) begin
            failures++;
            $display("FAIL collision_ack_wins: got done=%0d err=%0d expected done=1 err=0",
                     done_cnt, err_cnt);
        end
    endtask

    task automatic test_stray_ack();
        int changed = 0;
        bus.mem_ack_i = 1'b1;
        step();
        bus.mem_ack_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (outs() !== 8'h80) changed++;
            step();
        end
        checks++;
        if (changed != 0) begin
            failures++;
            $display("FAIL stray_ack: got %0d changed cycles (last %b) expected 0 (%b)",
                     changed, outs(), 8'h80);
        end
    endtask

    task automatic test_reset_mid_access();
        int gnt_cyc = 0;
        int err_cnt = 0;
        do_reset();
        bus.req0_i = 1'b1;
        step();
        step();
        step();
        checks++;
        if (bus.gnt0_o !== 1'b1) begin
            failures++;
            $display("FAIL midreset_setup: got gnt0=%b expected 1", bus.gnt0_o);
        end
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL midreset_async: got %b expected %b", outs(), 8'h00);
        end
        #1;
        rst_i = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.gnt0_o) gnt_cyc++;
            if (bus.err_o) begin
                err_cnt++;
                bus.req0_i = 1'b0;
            end
        end
        checks++;
        if (gnt_cyc != 4 || err_cnt != 1) begin
            failures++;
            $display("FAIL midreset_regrant: got gnt_cycles=%0d err=%0d expected 4 1",
                     gnt_cyc, err_cnt);
        end
    endtask

    task automatic test_req_drop();
        bus.req0_i = 1'b1;
        step();
        bus.req0_i = 1'b0;
        step();
        checks++;
        if (bus.gnt0_o !== 1'b1 || bus.mem_en_o !== 1'b1) begin
            failures++;
            $display("FAIL reqdrop_hold: got gnt0=%b en=%b expected 1 1",
                     bus.gnt0_o, bus.mem_en_o);
        end
        bus.mem_ack_i = 1'b1;
        step();
        bus.mem_ack_i = 1'b0;
        checks++;
        if ({bus.done0_o, bus.gnt0_o, bus.err_o} !== 3'b100) begin
            failures++;
            $display("FAIL reqdrop_done: got done0/gnt0/err=%b expected 100",
                     {bus.done0_o, bus.gnt0_o, bus.err_o});
        end
        step();
        checks++;
        if (outs() !== 8'h00) begin
            failures++;
            $display("FAIL reqdrop_idle: got %b expected %b", outs(), 8'h00);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_i    = 1'b0;
        test_reset();
        test_single_fetch();
        test_contention();
        test_watchdog();
        test_collision();
        test_stray_ack();
        test_reset_mid_access();
        test_req_drop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
